wb_sram_bridge: RTL and testbench

- Caravel-side Wishbone slave front-end that sits directly upstream of the core-memory split stage.
- Decodes a fixed address window on the 32-bit management Wishbone bus and registers each hit into a held request: 11-bit word address, byte enables, write data and we.
- Holds the request until the split stage returns rvalid, then issues exactly one wbs_ack_o with read data.
- Decouples bus timing from SRAM latency and provides an optional timeout.

---
 rtl/wb_sram_bridge.sv | 133 +++++++++++++
 tb/tb_wb_sram_bridge.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_sram_bridge.sv
// Wishbone slave front-end: registers one in-window request and holds it for the split stage until rvalid, then acks once.
// Optional REQ timeout with saturating error count when WB_SRAM_BRIDGE_TIMEOUT_EN is defined.
module wb_sram_bridge #(
  parameter logic [31:0] BASE_ADDR      = 32'h3000_0000,
  parameter int          TIMEOUT_CYCLES = 64
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic [10:0] mem_addr_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  output logic        mem_we_o,
  output logic        mem_stb_o,
  output logic        mem_cyc_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_rvalid_i,
  output logic [7:0]  err_cnt_o
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  logic [10:0] r_addr;
  logic [3:0]  r_be;
  logic [31:0] r_wdata;
  logic        r_we;
  logic        r_stb;
  logic        r_ack;
  logic [31:0] r_dat;
  logic        r_abort;
`ifdef WB_SRAM_BRIDGE_TIMEOUT_EN
  logic [15:0] r_tcnt;
  logic [7:0]  r_err_cnt;
`endif

  logic w_hit;
  logic w_abort_now;
  logic w_unused;

  assign w_hit       = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:13] == BASE_ADDR[31:13]);
  // The completing cycle itself can carry the cyc drop, so fold it into the ack decision.
  assign w_abort_now = r_abort | ~wbs_cyc_i;
  assign w_unused    = &{1'b0, wbs_adr_i[1:0], TMO_LAST};

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state   <= IDLE;
      r_addr    <= '0;
      r_be      <= '0;
      r_wdata   <= '0;
      r_we      <= 1'b0;
      r_stb     <= 1'b0;
      r_ack     <= 1'b0;
      r_dat     <= '0;
      r_abort   <= 1'b0;
`ifdef WB_SRAM_BRIDGE_TIMEOUT_EN
      r_tcnt    <= '0;
      r_err_cnt <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          r_ack   <= 1'b0;
          r_dat   <= '0;
          r_abort <= 1'b0;
          if (w_hit) begin
            r_addr  <= wbs_adr_i[12:2];
            r_be    <= wbs_sel_i;
            r_wdata <= wbs_dat_i;
            r_we    <= wbs_we_i;
            r_stb   <= 1'b1;
            r_state <= REQ;
`ifdef WB_SRAM_BRIDGE_TIMEOUT_EN
            r_tcnt  <= '0;
`endif
          end
        end
        REQ: begin
          if (!wbs_cyc_i) r_abort <= 1'b1;
          if (mem_rvalid_i) begin
            r_dat   <= r_we ? 32'h0 : mem_rdata_i;
            r_ack   <= ~w_abort_now;
            r_stb   <= 1'b0;
            r_state <= RESP;
          end
`ifdef WB_SRAM_BRIDGE_TIMEOUT_EN
          else if (r_tcnt == TMO_LAST) begin
            r_dat   <= 32'hDEAD_BEEF;
            r_ack   <= ~w_abort_now;
            r_stb   <= 1'b0;
            r_state <= RESP;
            if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
          end else begin
            r_tcnt <= r_tcnt + 16'd1;
          end
`endif
        end
        RESP: begin
          r_ack   <= 1'b0;
          r_dat   <= '0;
          r_abort <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign wbs_ack_o   = r_ack;
  assign wbs_dat_o   = r_dat;
  assign mem_addr_o  = r_addr;
  assign mem_be_o    = r_be;
  assign mem_wdata_o = r_wdata;
  assign mem_we_o    = r_we;
  assign mem_stb_o   = r_stb;
  assign mem_cyc_o   = r_stb;
`ifdef WB_SRAM_BRIDGE_TIMEOUT_EN
  assign err_cnt_o   = r_err_cnt;
`else
  assign err_cnt_o   = 8'd0;
`endif

endmodule

// File: tb/tb_wb_sram_bridge.sv
// Bench for wb_sram_bridge: acts as Wishbone master and as the split stage, backed by a word-array SRAM model.
module tb_wb_sram_bridge;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i;
  logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i, wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic [10:0] mem_addr_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_wdata_o;
  logic        mem_we_o, mem_stb_o, mem_cyc_o;
  logic [31:0] mem_rdata_i;
  logic        mem_rvalid_i;
  logic [7:0]  err_cnt_o;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] model_mem [0:2047];
  int exp_err = 0;

  wb_sram_bridge #(.BASE_ADDR(32'h3000_0000), .TIMEOUT_CYCLES(8)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .mem_addr_o(mem_addr_o), .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
    .mem_we_o(mem_we_o), .mem_stb_o(mem_stb_o), .mem_cyc_o(mem_cyc_o),
    .mem_rdata_i(mem_rdata_i), .mem_rvalid_i(mem_rvalid_i), .err_cnt_o(err_cnt_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  task automatic bus_idle();
    wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0; wbs_sel_i = 0;
    wbs_adr_i = 0; wbs_dat_i = 0;
  endtask

  // One transaction: rvalid sampled k edges after the request edge; ack is expected on the edge after that.
  task automatic run_txn(input logic [31:0] adr, input logic we, input logic [3:0] sel,
                         input logic [31:0] wd, input int k, input bit abort, input bit late_drop);
    logic [10:0] ea;
    logic [31:0] ed;
    ea = adr[12:2];
    ed = we ? 32'h0 : model_mem[ea];
    mem_rdata_i = we ? $urandom : model_mem[ea];
    wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = we; wbs_sel_i = sel;
    wbs_adr_i = adr; wbs_dat_i = wd;
    for (int i = 0; i <= k; i++) begin
      @(posedge wb_clk_i); #1;
      if (i < k) begin
        n_tests++;
        if ({mem_stb_o, mem_cyc_o, wbs_ack_o, mem_addr_o, mem_be_o, mem_we_o, mem_wdata_o} !==
            {1'b1, 1'b1, 1'b0, ea, sel, we, wd}) begin
          n_fail++;
          $display("FAIL req_hold cyc%0d: stb=%b cyc=%b ack=%b addr=%h be=%h we=%b wd=%h, want 1 1 0 %h %h %b %h",
                   i, mem_stb_o, mem_cyc_o, wbs_ack_o, mem_addr_o, mem_be_o, mem_we_o, mem_wdata_o, ea, sel, we, wd);
        end
        if (i == 0 && abort) begin wbs_cyc_i = 0; wbs_stb_i = 0; end
        if (i == k - 1) mem_rvalid_i = 1;
      end else begin
        n_tests++;
        if ({mem_stb_o, wbs_ack_o} !== {1'b0, ~abort} || (!abort && wbs_dat_o !== ed)) begin
          n_fail++;
          $display("FAIL resp: stb=%b ack=%b dat=%h, want stb=0 ack=%b dat=%h",
                   mem_stb_o, wbs_ack_o, wbs_dat_o, ~abort, ed);
        end
        mem_rvalid_i = 0;
        if (!late_drop) bus_idle();
      end
    end
    @(posedge wb_clk_i); #1;
    n_tests++;
    if ({wbs_ack_o, wbs_dat_o, mem_stb_o} !== 34'h0) begin
      n_fail++;
      $display("FAIL post_ack: ack=%b dat=%h stb=%b, want all 0", wbs_ack_o, wbs_dat_o, mem_stb_o);
    end
    bus_idle();
    @(posedge wb_clk_i); #1;
    n_tests++;
    if ({wbs_ack_o, mem_stb_o} !== 2'b00) begin
      n_fail++;
      $display("FAIL no_reaccept: ack=%b stb=%b, want 0 0", wbs_ack_o, mem_stb_o);
    end
    if (we) for (int b = 0; b < 4; b++) if (sel[b]) model_mem[ea][8*b +: 8] = wd[8*b +: 8];
  endtask

  task automatic test_reset();
    wb_rst_i = 1; mem_rvalid_i = 0; mem_rdata_i = 0; bus_idle();
    #3;
    n_tests++;
    if ({wbs_ack_o, wbs_dat_o, mem_addr_o, mem_be_o, mem_wdata_o, mem_we_o, mem_stb_o, mem_cyc_o, err_cnt_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: ack=%b dat=%h addr=%h stb=%b err=%0d, want all 0",
               wbs_ack_o, wbs_dat_o, mem_addr_o, mem_stb_o, err_cnt_o);
    end
    repeat (3) @(posedge wb_clk_i);
    #1 wb_rst_i = 0;
  endtask

  task automatic test_directed();
    model_mem[11'h7FF] = 32'h1234_5678;
    run_txn(32'h3000_0010, 1'b1, 4'hF, 32'hCAFE_F00D, 1, 1'b0, 1'b0);
    n_tests++;
    if (model_mem[11'h004] !== 32'hCAFE_F00D) begin
      n_fail++;
      $display("FAIL write_model: got %h want cafef00d", model_mem[11'h004]);
    end
    run_txn(32'h3000_1FFC, 1'b0, 4'hF, 32'h0, 3, 1'b0, 1'b0);
  endtask

  task automatic test_miss();
    wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 0; wbs_sel_i = 4'hF; wbs_adr_i = 32'h3000_2000;
    for (int i = 0; i < 10; i++) begin
      if (i == 5) wbs_adr_i = 32'h2FFF_FFFC;
      @(posedge wb_clk_i); #1;
      n_tests++;
      if ({mem_stb_o, wbs_ack_o} !== 2'b00) begin
        n_fail++;
        $display("FAIL miss cyc%0d: stb=%b ack=%b, want 0 0", i, mem_stb_o, wbs_ack_o);
      end
    end
    bus_idle();
    @(posedge wb_clk_i); #1;
  endtask

  task automatic test_abort();
    run_txn(32'h3000_0100, 1'b0, 4'hF, 32'h0, 3, 1'b1, 1'b0);
    run_txn(32'h3000_0104, 1'b1, 4'h5, 32'hA5A5_5A5A, 2, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_txn(32'h3000_0200, 1'b1, 4'hF, 32'h0BAD_F00D, 1, 1'b0, 1'b1);
    run_txn(32'h3000_0200, 1'b0, 4'hF, 32'h0, 1, 1'b0, 1'b1);
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      logic [31:0] a;
      a = 32'h3000_0000 | ($urandom & 32'h1FFC) | ($urandom & 32'h3);
      run_txn(a, 1'($urandom), 4'($urandom), $urandom, $urandom_range(1, 5),
              ($urandom_range(0, 7) == 0), 1'($urandom));
    end
  endtask

  task automatic test_reset_mid_req();
    wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 0; wbs_sel_i = 4'hF; wbs_adr_i = 32'h3000_0040;
    @(posedge wb_clk_i); #1;
    n_tests++;
    if (mem_stb_o !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_pre: stb=%b want 1", mem_stb_o);
    end
    wb_rst_i = 1;
    #1;
    n_tests++;
    if ({wbs_ack_o, wbs_dat_o, mem_addr_o, mem_be_o, mem_wdata_o, mem_we_o, mem_stb_o, mem_cyc_o, err_cnt_o} !== '0) begin
      n_fail++;
      $display("FAIL rst_mid: ack=%b addr=%h be=%h stb=%b cyc=%b err=%0d, want all 0",
               wbs_ack_o, mem_addr_o, mem_be_o, mem_stb_o, mem_cyc_o, err_cnt_o);
    end
    exp_err = 0;
    bus_idle();
    @(posedge wb_clk_i); #1;
    wb_rst_i = 0;
    mem_rvalid_i = 1;
    for (int i = 0; i < 3; i++) begin
      @(posedge wb_clk_i); #1;
      n_tests++;
      if ({wbs_ack_o, mem_stb_o} !== 2'b00) begin
        n_fail++;
        $display("FAIL rst_stray_rvalid cyc%0d: ack=%b stb=%b, want 0 0", i, wbs_ack_o, mem_stb_o);
      end
    end
    mem_rvalid_i = 0;
  endtask

`ifdef WB_SRAM_BRIDGE_TIMEOUT_EN
  task automatic test_timeout();
    wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 0; wbs_sel_i = 4'hF; wbs_adr_i = 32'h3000_0080;
    for (int i = 0; i <= 8; i++) begin
      @(posedge wb_clk_i); #1;
      n_tests++;
      if (i < 8 && {mem_stb_o, wbs_ack_o} !== 2'b10) begin
        n_fail++;
        $display("FAIL tmo_wait cyc%0d: stb=%b ack=%b, want 1 0", i, mem_stb_o, wbs_ack_o);
      end else if (i == 8 && {mem_stb_o, wbs_ack_o, wbs_dat_o, err_cnt_o} !== {1'b0, 1'b1, 32'hDEAD_BEEF, 8'd1}) begin
        n_fail++;
        $display("FAIL tmo_fire: stb=%b ack=%b dat=%h err=%0d, want 0 1 deadbeef 1",
                 mem_stb_o, wbs_ack_o, wbs_dat_o, err_cnt_o);
      end
    end
    bus_idle();
    @(posedge wb_clk_i); #1;
    exp_err = 1;
    run_txn(32'h3000_0084, 1'b0, 4'hF, 32'h0, 8, 1'b0, 1'b0);
    n_tests++;
    if (err_cnt_o !== 8'd1) begin
      n_fail++;
      $display("FAIL tmo_rvalid_wins: err=%0d want 1", err_cnt_o);
    end
    for (int n = 0; n < 300; n++) begin
      bit seen;
      seen = 0;
      wbs_cyc_i = 1; wbs_stb_i = 1; wbs_adr_i = 32'h3000_0000 | 32'(($urandom & 32'h1FFC));
      for (int c = 0; c < 20 && !seen; c++) begin
        @(posedge wb_clk_i); #1;
        if (wbs_ack_o) seen = 1;
      end
      exp_err = (exp_err < 255) ? exp_err + 1 : 255;
      if (!seen) begin
        n_tests++; n_fail++;
        $display("FAIL tmo_loop %0d: no ack within 20 cycles", n);
      end
      bus_idle();
      @(posedge wb_clk_i); #1;
    end
    n_tests++;
    if (err_cnt_o !== 8'(exp_err)) begin
      n_fail++;
      $display("FAIL tmo_saturate: err=%0d want %0d", err_cnt_o, exp_err);
    end
  endtask
`else
  task automatic test_timeout();
    wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 0; wbs_sel_i = 4'hF; wbs_adr_i = 32'h3000_0080;
    for (int i = 0; i < 100; i++) begin
      @(posedge wb_clk_i); #1;
      n_tests++;
      if ({mem_stb_o, wbs_ack_o, err_cnt_o} !== {1'b1, 1'b0, 8'd0}) begin
        n_fail++;
        $display("FAIL no_tmo cyc%0d: stb=%b ack=%b err=%0d, want 1 0 0", i, mem_stb_o, wbs_ack_o, err_cnt_o);
      end
    end
    bus_idle();
    run_txn(32'h3000_0080, 1'b0, 4'hF, 32'h0, 1, 1'b0, 1'b0);
  endtask
`endif

  initial begin
    for (int i = 0; i < 2048; i++) model_mem[i] = $urandom;
    test_reset();
    test_directed();
    test_miss();
    test_abort();
    test_back_to_back();
    test_random();
    test_reset_mid_req();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
